// File: rtl/fw_config_shifter.sv
`default_nettype none
// ============================================================================
// Module   : fw_config_shifter
// Purpose  : Serialises configuration words into the DUT pixel configuration
//            chain and returns the displaced chain contents as readback words.
// Revision : 1.0 - initial release
// ============================================================================

module fw_config_shifter #(
  parameter int CHAIN_LEN   = 768,
  parameter int WORD_W      = 32,
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 8,
  parameter int RST_CYCLES  = 16
) (
  input  logic              fw_pl_clk1,
  input  logic              fw_rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              chip_reset_req,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              fw_config_clk,
  output logic              fw_config_in,
  output logic              fw_config_load,
  output logic              fw_reset_not,
  input  logic              fw_config_out
);

  localparam int c_n_words   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int c_bit_w     = $clog2(CHAIN_LEN + 1);
  localparam int c_wcnt_w    = $clog2(c_n_words + 1);
  localparam int c_sh_w      = $clog2(WORD_W + 1);
  localparam int c_ph_w      = $clog2(2 * CLK_DIV);
  localparam int c_tmr_max   = (LOAD_CYCLES > RST_CYCLES) ? LOAD_CYCLES : RST_CYCLES;
  localparam int c_tmr_w     = $clog2(c_tmr_max + 1);

  localparam logic [c_bit_w-1:0]  c_chain_len  = c_bit_w'(CHAIN_LEN);
  localparam logic [c_wcnt_w-1:0] c_n_words_v  = c_wcnt_w'(c_n_words);
  localparam logic [c_ph_w-1:0]   c_ph_rise    = c_ph_w'(CLK_DIV - 1);
  localparam logic [c_ph_w-1:0]   c_ph_last    = c_ph_w'(2 * CLK_DIV - 1);
  localparam logic [c_sh_w-1:0]   c_word_w_v   = c_sh_w'(WORD_W);
  localparam logic [c_sh_w-1:0]   c_word_w_m1  = c_sh_w'(WORD_W - 1);
  localparam logic [c_tmr_w-1:0]  c_load_last  = c_tmr_w'(LOAD_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]  c_rst_last   = c_tmr_w'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RSTP  = 2'd1,
    S_SHIFT = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_clk;
  logic                r_cfg_in;
  logic                r_cfg_load;
  logic                r_reset_not;
  logic [WORD_W-1:0]   r_rb_word;
  logic                r_rb_valid;
  logic [WORD_W-1:0]   r_sr;
  logic [c_sh_w-1:0]   r_sr_cnt;
  logic [WORD_W-1:0]   r_pf;
  logic                r_pf_valid;
  logic [c_wcnt_w-1:0] r_words;
  logic [c_bit_w-1:0]  r_bits;
  logic [c_ph_w-1:0]   r_phase;
  logic                r_active;
  logic [WORD_W-1:0]   r_rb_acc;
  logic [c_sh_w-1:0]   r_rb_cnt;
  logic [c_tmr_w-1:0]  r_tmr;

  logic                w_accept;
  logic                w_boundary;
  logic                w_have_sr;
  logic                w_last_done;
  logic                w_take_new;
  logic [WORD_W-1:0]   w_rb_next;
  logic [c_sh_w-1:0]   w_rb_cnt_next;

  assign cfg_ready      = (r_state == S_SHIFT) && !r_pf_valid && (r_words < c_n_words_v);
  assign w_accept       = cfg_valid && cfg_ready;
  // A bit period ends on its last phase; an inactive engine is always at a boundary.
  assign w_boundary     = !r_active || (r_phase == c_ph_last);
  assign w_have_sr      = (r_sr_cnt != '0);
  assign w_last_done    = r_active && (r_bits == c_chain_len);
  assign w_take_new     = (r_state == S_SHIFT) && w_boundary && !w_last_done &&
                          !w_have_sr && !r_pf_valid && w_accept;
  assign w_rb_next      = {r_rb_acc[WORD_W-2:0], fw_config_out};
  assign w_rb_cnt_next  = r_rb_cnt + c_sh_w'(1);

  assign busy           = r_busy;
  assign done           = r_done;
  assign fw_config_clk  = r_cfg_clk;
  assign fw_config_in   = r_cfg_in;
  assign fw_config_load = r_cfg_load;
  assign fw_reset_not   = r_reset_not;
  assign rb_word        = r_rb_word;
  assign rb_valid       = r_rb_valid;

  always_ff @(posedge fw_pl_clk1) begin
    // Losing enable mid-operation is treated exactly like a reset.
    if (!fw_rst_n || ((r_state != S_IDLE) && !enable)) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_clk   <= 1'b0;
      r_cfg_in    <= 1'b0;
      r_cfg_load  <= 1'b1;
      r_reset_not <= 1'b1;
      r_rb_word   <= '0;
      r_rb_valid  <= 1'b0;
      r_sr        <= '0;
      r_sr_cnt    <= '0;
      r_pf        <= '0;
      r_pf_valid  <= 1'b0;
      r_words     <= '0;
      r_bits      <= '0;
      r_phase     <= '0;
      r_active    <= 1'b0;
      r_rb_acc    <= '0;
      r_rb_cnt    <= '0;
      r_tmr       <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && chip_reset_req) begin
            r_state     <= S_RSTP;
            r_busy      <= 1'b1;
            r_reset_not <= 1'b0;
            r_tmr       <= '0;
          end else if (enable && start) begin
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
            r_cfg_load <= 1'b0;
            r_sr_cnt   <= '0;
            r_pf_valid <= 1'b0;
            r_words    <= '0;
            r_bits     <= '0;
            r_phase    <= '0;
            r_active   <= 1'b0;
            r_rb_acc   <= '0;
            r_rb_cnt   <= '0;
          end
        end

        S_RSTP: begin
          if (r_tmr == c_rst_last) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_reset_not <= 1'b1;
          end else begin
            r_tmr <= r_tmr + c_tmr_w'(1);
          end
        end

        S_SHIFT: begin
          if (w_accept) begin
            r_words <= r_words + c_wcnt_w'(1);
            if (!w_take_new) begin
              r_pf       <= cfg_word;
              r_pf_valid <= 1'b1;
            end
          end

          if (!w_boundary) begin
            r_phase <= r_phase + c_ph_w'(1);
            if (r_phase == c_ph_rise) begin
              r_cfg_clk <= 1'b1;
            end
          end else begin
            if (r_active) begin
              if (w_rb_cnt_next == c_word_w_v) begin
                r_rb_word  <= w_rb_next;
                r_rb_valid <= 1'b1;
                r_rb_acc   <= '0;
                r_rb_cnt   <= '0;
              end else if (w_last_done) begin
                r_rb_word  <= w_rb_next << (c_word_w_v - w_rb_cnt_next);
                r_rb_valid <= 1'b1;
                r_rb_acc   <= '0;
                r_rb_cnt   <= '0;
              end else begin
                r_rb_acc <= w_rb_next;
                r_rb_cnt <= w_rb_cnt_next;
              end
            end

            if (w_last_done) begin
              r_state   <= S_LOAD;
              r_cfg_clk <= 1'b0;
              r_cfg_in  <= 1'b0;
              r_active  <= 1'b0;
              r_tmr     <= '0;
            end else if (w_have_sr || r_pf_valid || w_accept) begin
              if (w_have_sr) begin
                r_cfg_in <= r_sr[WORD_W-1];
                r_sr     <= r_sr << 1;
                r_sr_cnt <= r_sr_cnt - c_sh_w'(1);
              end else if (r_pf_valid) begin
                r_cfg_in   <= r_pf[WORD_W-1];
                r_sr       <= r_pf << 1;
                r_sr_cnt   <= c_word_w_m1;
                r_pf_valid <= 1'b0;
              end else begin
                r_cfg_in <= cfg_word[WORD_W-1];
                r_sr     <= cfg_word << 1;
                r_sr_cnt <= c_word_w_m1;
              end
              r_bits    <= r_bits + c_bit_w'(1);
              r_phase   <= '0;
              r_active  <= 1'b1;
              r_cfg_clk <= 1'b0;
            end else begin
              r_active  <= 1'b0;
              r_cfg_clk <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_tmr == c_load_last) begin
            r_cfg_load <= 1'b1;
            r_done     <= 1'b1;
          end else begin
            r_tmr <= r_tmr + c_tmr_w'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
